// File: rtl/ps2_hex_entry_ctrl_pkg.sv
// Shared PS/2 scan-code constants, controller state type and decoder flag layout.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam int unsigned NUMBER_F = 0;
  localparam int unsigned ENTER_F  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXT   = 2'd1,
    S_BREAK = 2'd2
  } state_t;

endpackage

// File: rtl/ps2_hex_entry_ctrl_dc.sv
// Combinational keycode decoder: maps set-2 main-row hex keys to a nibble and
// flags Enter; all other codes decode with both flags clear.
module PS2_DC
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  output logic [3:0] nibble_o,
  output logic [1:0] flags_o
);

  logic is_num;

  always_comb begin
    nibble_o = '0;
    is_num   = 1'b1;
    unique case (code_i)
      8'h45: nibble_o = 4'h0;
      8'h16: nibble_o = 4'h1;
      8'h1E: nibble_o = 4'h2;
      8'h26: nibble_o = 4'h3;
      8'h25: nibble_o = 4'h4;
      8'h2E: nibble_o = 4'h5;
      8'h36: nibble_o = 4'h6;
      8'h3D: nibble_o = 4'h7;
      8'h3E: nibble_o = 4'h8;
      8'h46: nibble_o = 4'h9;
      8'h1C: nibble_o = 4'hA;
      8'h32: nibble_o = 4'hB;
      8'h21: nibble_o = 4'hC;
      8'h23: nibble_o = 4'hD;
      8'h24: nibble_o = 4'hE;
      8'h2B: nibble_o = 4'hF;
      default: is_num = 1'b0;
    endcase
  end

  always_comb begin
    flags_o           = '0;
    flags_o[NUMBER_F] = is_num;
    flags_o[ENTER_F]  = (code_i == SC_ENTER);
  end

endmodule

// File: rtl/ps2_hex_entry_ctrl.sv
// Turns a PS/2 scan-code byte stream into committed multi-digit hex numbers,
// honouring F0 (break) and E0 (extended) prefixes.
module ps2_hex_entry_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CW     = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          scan_code,
  input  logic                scan_valid,
  output logic [4*DIGITS-1:0] entry,
  output logic [CW-1:0]       digit_count,
  output logic [4*DIGITS-1:0] value_out,
  output logic                value_valid,
  output logic                overflow
);

  localparam int unsigned W = 4 * DIGITS;
  localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

  state_t          state_q;
  logic [W-1:0]    entry_q;
  logic [CW-1:0]   count_q;
  logic [W-1:0]    value_q;
  logic            valid_q;
  logic            ovf_q;

  logic [3:0]      dc_nibble;
  logic [1:0]      dc_flags;
  logic            commit_d;
  logic            has_digits;

  PS2_DC u_dc (
    .code_i   (scan_code),
    .nibble_o (dc_nibble),
    .flags_o  (dc_flags)
  );

  // Enter commits from either the plain (decoder-flagged) or the keypad (E0-prefixed) path.
  always_comb begin
    has_digits = (count_q != '0);
    commit_d   = 1'b0;
    if (scan_valid && has_digits) begin
      if (state_q == S_IDLE && dc_flags[ENTER_F])
        commit_d = 1'b1;
      else if (state_q == S_EXT && scan_code == SC_ENTER)
        commit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      count_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (commit_d) begin
        value_q <= entry_q;
        valid_q <= 1'b1;
        entry_q <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
      if (scan_valid) begin
        unique case (state_q)
          S_IDLE: begin
            if (scan_code == SC_BREAK) begin
              state_q <= S_BREAK;
            end else if (scan_code == SC_EXT) begin
              state_q <= S_EXT;
            end else if (dc_flags[NUMBER_F]) begin
              if (count_q < MAX_CNT) begin
                entry_q <= {entry_q[W-5:0], dc_nibble};
                count_q <= count_q + CW'(1);
              end else begin
                ovf_q <= 1'b1;
              end
            end else if (scan_code == SC_BKSP) begin
              if (has_digits) begin
                entry_q <= entry_q >> 4;
                count_q <= count_q - CW'(1);
              end
            end else if (scan_code == SC_ESC) begin
              entry_q <= '0;
              count_q <= '0;
              ovf_q   <= 1'b0;
            end
          end
          S_EXT: begin
            if (scan_code == SC_BREAK)
              state_q <= S_BREAK;
            else if (scan_code == SC_EXT)
              state_q <= S_EXT;
            else
              state_q <= S_IDLE;
          end
          S_BREAK: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign entry       = entry_q;
  assign digit_count = count_q;
  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_hex_entry_ctrl.sv
// Self-checking bench for ps2_hex_entry_ctrl: queue-based reference model
// compared every cycle, plus hand-computed checkpoints from the test plan.
module tb_ps2_hex_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int CW     = $clog2(DIGITS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    scan_code;
  logic          scan_valid;
  logic [W-1:0]  entry;
  logic [CW-1:0] digit_count;
  logic [W-1:0]  value_out;
  logic          value_valid;
  logic          overflow;

  ps2_hex_entry_ctrl #(.DIGITS(DIGITS), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .entry       (entry),
    .digit_count (digit_count),
    .value_out   (value_out),
    .value_valid (value_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits held as a queue of nibbles, oldest first.
  int   m_digits[$];
  logic [W-1:0] m_value = '0;
  bit   m_vv = 0, m_ovf = 0, m_after_f0 = 0, m_after_e0 = 0;
  bit   chk_en = 0;

  function automatic bit hex_key(input logic [7:0] b, output int n);
    logic [7:0] keys [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    n = 0;
    for (int i = 0; i < 16; i++)
      if (keys[i] == b) begin
        n = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_entry();
    logic [W-1:0] v = '0;
    foreach (m_digits[i]) v = v * 16 + W'(m_digits[i]);
    return v;
  endfunction

  task automatic m_commit();
    if (m_digits.size() > 0) begin
      m_value = m_entry();
      m_vv = 1;
      m_digits.delete();
      m_ovf = 0;
    end
  endtask

  always @(posedge clk) begin
    int n;
    if (rst) begin
      m_digits.delete();
      m_value = '0; m_vv = 0; m_ovf = 0; m_after_f0 = 0; m_after_e0 = 0;
    end else begin
      m_vv = 0;
      if (scan_valid) begin
        if (m_after_f0) begin
          m_after_f0 = 0;
        end else if (m_after_e0) begin
          if (scan_code == 8'hF0) begin m_after_e0 = 0; m_after_f0 = 1; end
          else if (scan_code != 8'hE0) begin
            m_after_e0 = 0;
            if (scan_code == 8'h5A) m_commit();
          end
        end else if (scan_code == 8'hF0) m_after_f0 = 1;
        else if (scan_code == 8'hE0) m_after_e0 = 1;
        else if (hex_key(scan_code, n)) begin
          if (m_digits.size() < DIGITS) m_digits.push_back(n);
          else m_ovf = 1;
        end
        else if (scan_code == 8'h5A) m_commit();
        else if (scan_code == 8'h66) begin
          if (m_digits.size() > 0) void'(m_digits.pop_back());
        end
        else if (scan_code == 8'h76) begin
          m_digits.delete();
          m_ovf = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("entry",       32'(entry),       32'(m_entry()));
      check("digit_count", 32'(digit_count), 32'(m_digits.size()));
      check("value_out",   32'(value_out),   32'(m_value));
      check("value_valid", 32'(value_valid), 32'(m_vv));
      check("overflow",    32'(overflow),    32'(m_ovf));
    end
  end

  // One strobe per call; returns on the negedge after the consuming posedge.
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] burst [12] = '{8'h24, 8'h2B, 8'hAA, 8'hFA, 8'h45, 8'h66, 8'h36,
                               8'hE0, 8'hE0, 8'h5A, 8'h3D, 8'h5A};
    rst = 1'b1; scan_code = '0; scan_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    check("rst_entry", 32'(entry), 32'h0);
    check("rst_value", 32'(value_out), 32'h0);
    rst = 1'b0;
    idle(1);

    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("tp1_entry", 32'(entry), 32'h1234);
    send(8'h5A);
    check("tp1_value", 32'(value_out), 32'h1234);
    check("tp1_vv", 32'(value_valid), 32'h1);
    check("tp1_cnt", 32'(digit_count), 32'h0);
    idle(1);
    check("tp1_vv_low", 32'(value_valid), 32'h0);

    send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32);
    check("tp2_entry", 32'(entry), 32'h00AB);
    check("tp2_cnt", 32'(digit_count), 32'h2);

    send(8'hE0); send(8'h5A);
    check("tp4_value", 32'(value_out), 32'h00AB);
    check("tp4_vv", 32'(value_valid), 32'h1);
    send(8'h5A);
    check("tp4_nopulse", 32'(value_valid), 32'h0);

    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    check("tp3_entry", 32'(entry), 32'h1234);
    check("tp3_ovf", 32'(overflow), 32'h1);
    send(8'h66);
    check("tp3_bksp", 32'(entry), 32'h0123);
    check("tp3_cnt", 32'(digit_count), 32'h3);
    send(8'h76);
    check("tp3_esc", 32'(entry), 32'h0);
    check("tp3_ovf_clr", 32'(overflow), 32'h0);
    check("tp3_value_kept", 32'(value_out), 32'h00AB);

    send(8'h1C); send(8'hE0); send(8'hF0); send(8'h5A);
    check("tp5_entry", 32'(entry), 32'h000A);
    check("tp5_vv", 32'(value_valid), 32'h0);
    send(8'h16);
    check("tp5_next", 32'(entry), 32'h00A1);

    // Back-to-back strobes, including ignored AA/FA and a keypad Enter.
    foreach (burst[i]) begin
      scan_code = burst[i]; scan_valid = 1'b1;
      @(negedge clk);
    end
    scan_valid = 1'b0;
    idle(2);

    send(8'h16); send(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    check("tp6_rst_entry", 32'(entry), 32'h0);
    check("tp6_rst_cnt", 32'(digit_count), 32'h0);
    check("tp6_rst_value", 32'(value_out), 32'h0);
    rst = 1'b0;
    send(8'h16);
    check("tp6_entry", 32'(entry), 32'h1);
    check("tp6_cnt", 32'(digit_count), 32'h1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_hex_entry_ctrl.md
Name: ps2_hex_entry_ctrl

Overview:
- Sequences raw PS/2 scan-code bytes into multi-digit hex numbers.
- Tracks make, break (F0) and extended (E0) prefixes so each key is acted on once per make code. Uses the keycode-to-hex decoder to classify bytes.
- Accumulates up to DIGITS nibbles and emits the number on Enter.
- Sits between the PS/2 byte receiver and downstream consumers (display, register loader).

Parameters:
- DIGITS, 4, maximum hex digits held; value width W = 4*DIGITS.
- CW, $clog2(DIGITS+1), width of digit_count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- scan_code  in  8  byte from PS/2 receiver.
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
- entry  out  W  live digit buffer; newest digit in bits [3:0].
- digit_count  out  CW  digits currently held, 0..DIGITS.
- value_out  out  W  last committed number; holds until the next commit.
- value_valid  out  1  one-cycle pulse when value_out updates.
- overflow  out  1  sticky: a digit was rejected because the buffer was full.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: entry=0, digit_count=0, value_out=0, value_valid=0, overflow=0, FSM=S_IDLE.
- Reset mid-sequence drops any pending F0/E0 prefix.
- Bytes are consumed only when scan_valid=1. All outputs are registered: the effect appears the cycle after the strobe.
- FSM states: S_IDLE, S_EXT, S_BREAK.
- S_IDLE:
  - F0 -> S_BREAK; E0 -> S_EXT.
  - Any other byte is a make code: act on it and stay in S_IDLE.
- S_EXT:
  - F0 -> S_BREAK.
  - 5A (keypad Enter) -> Enter action, -> S_IDLE.
  - E0 -> stay in S_EXT.
  - Any other byte is ignored, -> S_IDLE.
- S_BREAK: the next byte, whatever its value, is discarded -> S_IDLE. Key release never acts.
- Make-code actions in S_IDLE:
  - Hex digit key (decoder number flag set):
    - If digit_count<DIGITS: entry <= {entry[W-5:0], nibble}; digit_count++.
    - Else: entry and digit_count unchanged; overflow <= 1.
  - Enter 5A:
    - If digit_count>0: value_out <= entry; value_valid=1 for exactly one cycle; entry<=0; digit_count<=0; overflow<=0.
    - If digit_count==0: no pulse, no change.
  - Backspace 66: if digit_count>0, entry <= entry>>4 and digit_count--; at 0 no change.
  - Escape 76: entry<=0, digit_count<=0, overflow<=0; value_out unchanged.
  - Any other byte (including AA and FA): ignored.
- Typematic repeat (repeated make codes with no break) counts as separate keystrokes.
- Enter latency: value_valid is high in the cycle after the 5A strobe and low in the following cycle, unless another commit strobe arrives.
- Back-to-back strobes in consecutive cycles are all processed. No backpressure is applied.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_ENTER=5A, SC_BKSP=66, SC_ESC=76.
  - FSM state typedef (2-bit encoding).
  - decoder flag bit indices NUMBER_F=0, ENTER_F=1.
- One sub-module: instantiate the existing combinational keycode decoder PS2_DC for nibble and flags.
- The controller uses the decoder only in S_IDLE; prefix and break handling stays in the FSM.

Test Plan:
- Bytes 16,1E,26,25 then 5A -> entry 1234 after the 4th byte; next cycle value_out=0x1234, value_valid=1 for one cycle; entry=0, digit_count=0.
- Bytes 1C, F0, 1C, 32 -> break byte ignored; entry=0x00AB, digit_count=2.
- Five digits 16,1E,26,25,2E -> entry=0x1234, overflow=1. Then 66 -> entry=0x0123, digit_count=3. Then 76 -> entry=0, overflow=0.
- E0, 5A with entry 0x00AB -> value_out=0x00AB, value_valid pulse. A lone 5A with digit_count=0 -> no pulse.
- E0, F0, 5A -> no commit, FSM returns to S_IDLE, entry unchanged. Next byte 16 is accepted as digit 1.
- F0 strobe, then rst high for one cycle, then 16 -> 16 is accepted as digit 1 (pending break dropped); all outputs zero during reset.
